// File: rtl/a2_bridge_arbiter.sv
// Fixed-priority arbiter sharing the multiplexed A2 bridge between N_REQ requesters.
// Parks the bridge in an idle read of IDLE_SEL between transfers and publishes the sampled byte.
module a2_bridge_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter logic [2:0]  IDLE_SEL      = 3'd0,
    parameter int unsigned IDLE_SETTLE   = 1
) (
    input  logic                 clk_logic,
    input  logic                 device_reset,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ-1:0]     we_i,
    input  logic [3*N_REQ-1:0]   sel_i,
    input  logic [8*N_REQ-1:0]   wdata_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [7:0]           rdata_o,
    output logic                 busy_o,
    output logic [7:0]           idle_data_o,
    output logic                 idle_valid_o,
    output logic [2:0]           a2_bridge_sel_o,
    output logic                 a2_bridge_rd_n_o,
    output logic                 a2_bridge_wr_n_o,
    output logic [7:0]           a2_bridge_d_o,
    output logic                 a2_bridge_d_oe_o,
    input  logic [7:0]           a2_bridge_d_i
);

    localparam int unsigned IDX_W       = $clog2(N_REQ);
    localparam logic [3:0]  SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0]  HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]  SETTLE      = 4'(IDLE_SETTLE);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t             st, st_nx;
    logic [3:0]         phase, phase_nx;
    logic [3:0]         idle_cnt, idle_cnt_nx;
    logic [IDX_W-1:0]   lat_idx, lat_idx_nx;
    logic               lat_we, lat_we_nx;
    logic [2:0]         lat_sel, lat_sel_nx;
    logic [7:0]         lat_wdata, lat_wdata_nx;

    logic [N_REQ-1:0]   req_m;
    logic               found;
    logic [N_REQ-1:0]   ack_nx;
    logic [7:0]         rdata_nx;
    logic [7:0]         idle_data_nx;
    logic               idle_valid_nx;
    logic [2:0]         sel_nx;
    logic               rd_n_nx;
    logic               wr_n_nx;
    logic [7:0]         d_o_nx;
    logic               d_oe_nx;

    always_comb begin
        st_nx        = st;
        phase_nx     = phase;
        lat_idx_nx   = lat_idx;
        lat_we_nx    = lat_we;
        lat_sel_nx   = lat_sel;
        lat_wdata_nx = lat_wdata;
        ack_nx       = '0;
        rdata_nx     = rdata_o;
        found        = 1'b0;

        // A requester still holding req during its own ack cycle must not win again.
        req_m = req_i & ~ack_o;

        case (st)
            ST_IDLE: begin
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    if (req_m[k] && !found) begin
                        found        = 1'b1;
                        lat_idx_nx   = IDX_W'(k);
                        lat_we_nx    = we_i[k];
                        lat_sel_nx   = sel_i[3*k +: 3];
                        lat_wdata_nx = wdata_i[8*k +: 8];
                    end
                end
                if (found) begin
                    st_nx    = ST_SETUP;
                    phase_nx = '0;
                end
            end
            ST_SETUP: begin
                if (phase == SETUP_LAST) begin
                    st_nx    = ST_STROBE;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            ST_STROBE: begin
                if (phase == STROBE_LAST) begin
                    if (!lat_we) rdata_nx = a2_bridge_d_i;
                    st_nx    = ST_HOLD;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            ST_HOLD: begin
                if (phase == HOLD_LAST) begin
                    st_nx            = ST_IDLE;
                    phase_nx         = '0;
                    ack_nx[lat_idx]  = 1'b1;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            default: begin
                st_nx    = ST_IDLE;
                phase_nx = '0;
            end
        endcase

        // Outputs are registered from the next state so pins line up with the state they describe.
        sel_nx  = (st_nx == ST_IDLE) ? IDLE_SEL : lat_sel_nx;
        rd_n_nx = !((st_nx == ST_IDLE) || (st_nx == ST_STROBE && !lat_we_nx));
        wr_n_nx = !(st_nx == ST_STROBE && lat_we_nx);
        d_oe_nx = (st_nx != ST_IDLE) && lat_we_nx;
        d_o_nx  = (st_nx == ST_IDLE) ? '0 : lat_wdata_nx;

        if (st_nx == ST_IDLE)
            idle_cnt_nx = (idle_cnt == 4'd15) ? 4'd15 : idle_cnt + 4'd1;
        else
            idle_cnt_nx = '0;
        idle_valid_nx = (st_nx == ST_IDLE) && (idle_cnt_nx >= SETTLE);
        idle_data_nx  = idle_valid_nx ? a2_bridge_d_i : idle_data_o;
    end

    always_ff @(posedge clk_logic) begin
        if (device_reset) begin
            st               <= ST_IDLE;
            phase            <= '0;
            idle_cnt         <= '0;
            lat_idx          <= '0;
            lat_we           <= 1'b0;
            lat_sel          <= '0;
            lat_wdata        <= '0;
            ack_o            <= '0;
            rdata_o          <= '0;
            busy_o           <= 1'b0;
            idle_data_o      <= '0;
            idle_valid_o     <= 1'b0;
            a2_bridge_sel_o  <= IDLE_SEL;
            a2_bridge_rd_n_o <= 1'b1;
            a2_bridge_wr_n_o <= 1'b1;
            a2_bridge_d_o    <= '0;
            a2_bridge_d_oe_o <= 1'b0;
        end else begin
            st               <= st_nx;
            phase            <= phase_nx;
            idle_cnt         <= idle_cnt_nx;
            lat_idx          <= lat_idx_nx;
            lat_we           <= lat_we_nx;
            lat_sel          <= lat_sel_nx;
            lat_wdata        <= lat_wdata_nx;
            ack_o            <= ack_nx;
            rdata_o          <= rdata_nx;
            busy_o           <= (st_nx != ST_IDLE);
            idle_data_o      <= idle_data_nx;
            idle_valid_o     <= idle_valid_nx;
            a2_bridge_sel_o  <= sel_nx;
            a2_bridge_rd_n_o <= rd_n_nx;
            a2_bridge_wr_n_o <= wr_n_nx;
            a2_bridge_d_o    <= d_o_nx;
            a2_bridge_d_oe_o <= d_oe_nx;
        end
    end

endmodule

// File: tb/tb_a2_bridge_arbiter.sv
// Directed bench for a2_bridge_arbiter: acks and read data checked by a scoreboard monitor,
// per-cycle bridge pin expectations checked inline by the stimulus.
`timescale 1ns/1ps
module tb_a2_bridge_arbiter;

    logic        clk_logic = 1'b0;
    logic        device_reset;
    logic [3:0]  req_i;
    logic [3:0]  we_i;
    logic [11:0] sel_i;
    logic [31:0] wdata_i;
    logic [3:0]  ack_o;
    logic [7:0]  rdata_o;
    logic        busy_o;
    logic [7:0]  idle_data_o;
    logic        idle_valid_o;
    logic [2:0]  a2_bridge_sel_o;
    logic        a2_bridge_rd_n_o;
    logic        a2_bridge_wr_n_o;
    logic [7:0]  a2_bridge_d_o;
    logic        a2_bridge_d_oe_o;
    logic [7:0]  a2_bridge_d_i;

    a2_bridge_arbiter #(.N_REQ(4), .IDLE_SEL(3'd0), .IDLE_SETTLE(3)) dut (
        .clk_logic        (clk_logic),
        .device_reset     (device_reset),
        .req_i            (req_i),
        .we_i             (we_i),
        .sel_i            (sel_i),
        .wdata_i          (wdata_i),
        .ack_o            (ack_o),
        .rdata_o          (rdata_o),
        .busy_o           (busy_o),
        .idle_data_o      (idle_data_o),
        .idle_valid_o     (idle_valid_o),
        .a2_bridge_sel_o  (a2_bridge_sel_o),
        .a2_bridge_rd_n_o (a2_bridge_rd_n_o),
        .a2_bridge_wr_n_o (a2_bridge_wr_n_o),
        .a2_bridge_d_o    (a2_bridge_d_o),
        .a2_bridge_d_oe_o (a2_bridge_d_oe_o),
        .a2_bridge_d_i    (a2_bridge_d_i)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct {
        int         cyc;
        logic [3:0] ack;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    always @(posedge clk_logic) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_logic);
        #1;
    endtask

    // Scoreboard monitor: every ack must match the next queued expectation.
    always @(negedge clk_logic) begin
        if (ack_o != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack at cycle %0d: got %0h, wanted none", cyc, ack_o);
            end else begin
                mon_e = sb.pop_front();
                check("ack_cycle", cyc, mon_e.cyc);
                check("ack_vector", {28'd0, ack_o}, {28'd0, mon_e.ack});
                check("ack_rdata", {24'd0, rdata_o}, {24'd0, mon_e.rdata});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, wanted completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        device_reset  = 1'b1;
        req_i         = '0;
        we_i          = '0;
        sel_i         = '0;
        wdata_i       = '0;
        a2_bridge_d_i = 8'h00;
        repeat (3) tick();
        check("rst_sel", a2_bridge_sel_o, 3'd0);
        check("rst_rd_n", a2_bridge_rd_n_o, 1'b1);
        check("rst_wr_n", a2_bridge_wr_n_o, 1'b1);
        check("rst_d_o", a2_bridge_d_o, 8'h00);
        check("rst_d_oe", a2_bridge_d_oe_o, 1'b0);
        check("rst_ack", ack_o, 4'h0);
        check("rst_rdata", rdata_o, 8'h00);
        check("rst_idle_data", idle_data_o, 8'h00);
        check("rst_idle_valid", idle_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        device_reset = 1'b0;
        repeat (3) tick();

        // Single read by requester 2 with select 2; d_i carries A5 only during STROBE.
        tick();
        t0      = cyc;
        req_i   = 4'b0100;
        we_i    = 4'b0000;
        sel_i   = {3'd7, 3'd2, 3'd7, 3'd7};
        wdata_i = 32'hFFFF_FFFF;
        sb.push_back('{cyc: t0 + 4, ack: 4'b0100, rdata: 8'hA5});
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("rd_sel", a2_bridge_sel_o, 3'd2);
            check("rd_rd_n", a2_bridge_rd_n_o, (i == 2) ? 1'b0 : 1'b1);
            check("rd_wr_n", a2_bridge_wr_n_o, 1'b1);
            check("rd_d_oe", a2_bridge_d_oe_o, 1'b0);
            if (i == 2) a2_bridge_d_i = 8'hA5;
            if (i == 3) a2_bridge_d_i = 8'h00;
        end
        tick();
        check("rd_ack_busy", busy_o, 1'b0);
        check("rd_ack_park_rd_n", a2_bridge_rd_n_o, 1'b0);
        check("rd_ack_park_sel", a2_bridge_sel_o, 3'd0);
        tick();
        req_i = 4'b0000;
        check("rd_masked_no_regrant", busy_o, 1'b0);

        // Single write by requester 1; write data changes after grant must not leak through.
        tick();
        t0      = cyc;
        req_i   = 4'b0010;
        we_i    = 4'b0010;
        sel_i   = {3'd7, 3'd7, 3'd1, 3'd7};
        wdata_i = {8'hFF, 8'hFF, 8'h3C, 8'hFF};
        sb.push_back('{cyc: t0 + 4, ack: 4'b0010, rdata: 8'hA5});
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) begin
                wdata_i = '0;
                sel_i   = '0;
                we_i    = '0;
            end
            check("wr_sel", a2_bridge_sel_o, 3'd1);
            check("wr_d_o", a2_bridge_d_o, 8'h3C);
            check("wr_d_oe", a2_bridge_d_oe_o, 1'b1);
            check("wr_wr_n", a2_bridge_wr_n_o, (i == 2) ? 1'b0 : 1'b1);
            check("wr_rd_n", a2_bridge_rd_n_o, 1'b1);
        end
        tick();
        check("wr_ack_d_oe", a2_bridge_d_oe_o, 1'b0);
        tick();
        req_i = 4'b0000;

        // Contention: requesters 0 (write), 1 and 3 (reads) all at once.
        tick();
        t0      = cyc;
        req_i   = 4'b1011;
        we_i    = 4'b0001;
        sel_i   = {3'd6, 3'd7, 3'd4, 3'd3};
        wdata_i = {8'h00, 8'h00, 8'h00, 8'h42};
        sb.push_back('{cyc: t0 + 4, ack: 4'b0001, rdata: 8'hA5});
        sb.push_back('{cyc: t0 + 8, ack: 4'b0010, rdata: 8'h5A});
        sb.push_back('{cyc: t0 + 12, ack: 4'b1000, rdata: 8'hC3});
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 1) begin
                check("cont_first_sel", a2_bridge_sel_o, 3'd3);
                check("cont_first_d_o", a2_bridge_d_o, 8'h42);
            end
            if (i == 5) begin
                check("cont_no_gap_1", busy_o, 1'b1);
                check("cont_second_sel", a2_bridge_sel_o, 3'd4);
                req_i[0]      = 1'b0;
                a2_bridge_d_i = 8'h5A;
            end
            if (i == 9) begin
                check("cont_no_gap_3", busy_o, 1'b1);
                check("cont_third_sel", a2_bridge_sel_o, 3'd6);
                req_i[1]      = 1'b0;
                a2_bridge_d_i = 8'hC3;
            end
            if (i == 13) req_i[3] = 1'b0;
        end

        // Requester 0 holds req one cycle past its ack while 2 waits; then idle sampling.
        tick();
        t0      = cyc;
        req_i   = 4'b0001;
        we_i    = 4'b0001;
        sel_i   = {3'd7, 3'd7, 3'd7, 3'd2};
        wdata_i = {8'h00, 8'h00, 8'h00, 8'h11};
        sb.push_back('{cyc: t0 + 4, ack: 4'b0001, rdata: 8'hC3});
        tick();
        req_i         = 4'b0101;
        sel_i         = {3'd7, 3'd6, 3'd7, 3'd2};
        a2_bridge_d_i = 8'h7E;
        sb.push_back('{cyc: t0 + 8, ack: 4'b0100, rdata: 8'h7E});
        for (int i = 2; i <= 14; i++) begin
            tick();
            if (i == 5) begin
                check("held_req2_granted_busy", busy_o, 1'b1);
                check("held_req2_sel", a2_bridge_sel_o, 3'd6);
            end
            if (i == 6) req_i[0] = 1'b0;
            if (i == 9) req_i[2] = 1'b0;
            if (i >= 8 && i <= 13) begin
                check("idle_valid", idle_valid_o, (i - 7 >= 3) ? 1'b1 : 1'b0);
                check("idle_rd_n", a2_bridge_rd_n_o, 1'b0);
                check("idle_sel", a2_bridge_sel_o, 3'd0);
                check("idle_busy", busy_o, 1'b0);
                if (i - 7 >= 3)
                    check("idle_data", idle_data_o, (i - 7 <= 4) ? 8'h7E : 8'h81);
                if (i == 11) a2_bridge_d_i = 8'h81;
            end
        end

        // Reset during the STROBE of a write aborts it; the held request is granted again.
        tick();
        t0      = cyc;
        req_i   = 4'b0010;
        we_i    = 4'b0010;
        sel_i   = {3'd7, 3'd7, 3'd5, 3'd7};
        wdata_i = {8'h00, 8'h00, 8'h99, 8'h00};
        tick();
        tick();
        check("rst_mid_strobe_wr_n", a2_bridge_wr_n_o, 1'b0);
        device_reset = 1'b1;
        tick();
        check("abort_wr_n", a2_bridge_wr_n_o, 1'b1);
        check("abort_d_oe", a2_bridge_d_oe_o, 1'b0);
        check("abort_sel", a2_bridge_sel_o, 3'd0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_rdata", rdata_o, 8'h00);
        check("abort_idle_data", idle_data_o, 8'h00);
        device_reset = 1'b0;
        sb.push_back('{cyc: t0 + 7, ack: 4'b0010, rdata: 8'h00});
        tick();
        check("regrant_sel", a2_bridge_sel_o, 3'd5);
        check("regrant_d_o", a2_bridge_d_o, 8'h99);
        check("regrant_d_oe", a2_bridge_d_oe_o, 1'b1);
        check("regrant_wr_n", a2_bridge_wr_n_o, 1'b1);
        repeat (4) tick();
        req_i = 4'b0000;
        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2_bridge_arbiter.md
Name: a2_bridge_arbiter

Overview:
Shares the single 8-bit multiplexed A2 bridge (3-bit select, active-low rd/wr strobes, bidirectional data) between N requesters. Each requester includes the bus address/data sampler, data-out driver, GPIO control writer and dip-switch init.
- Runs one bridge transfer at a time, with parameterised setup/strobe/hold timing.
- Arbitrates with fixed priority.
- Between transfers, parks the bridge in an idle-read of a configurable select and publishes the sampled byte.
- Sits between the bus-interface logic and the top-level a2_bridge_* pins.

Parameters:
N_REQ, 4, number of requesters (2..8); index 0 = highest priority.
SETUP_CYCLES, 1, cycles select and write data are stable before the strobe (1..15).
STROBE_CYCLES, 1, cycles rd_n or wr_n is held low (1..15).
HOLD_CYCLES, 1, cycles select and data are held after the strobe is released (1..15).
IDLE_SEL, 3'd0, bridge select driven while parked.
IDLE_SETTLE, 1, consecutive idle cycles before the first idle sample is valid (1..15).

Ports:
clk_logic  in  1  logic clock; all state on rising edge.
device_reset  in  1  synchronous, active-high reset.
req_i  in  N_REQ  per-requester request level; held until ack.
we_i  in  N_REQ  per-requester 1 = write, 0 = read; sampled at grant.
sel_i  in  3*N_REQ  per-requester bridge select (slice k = [3k+2:3k]); sampled at grant.
wdata_i  in  8*N_REQ  per-requester write byte (slice k = [8k+7:8k]); sampled at grant.
ack_o  out  N_REQ  one-cycle completion pulse to the granted requester.
rdata_o  out  8  byte captured by the most recent read transfer.
busy_o  out  1  high whenever the state is not IDLE.
idle_data_o  out  8  latest byte sampled while parked.
idle_valid_o  out  1  high in cycles where idle_data_o was updated this cycle.
a2_bridge_sel_o  out  3  bridge select.
a2_bridge_rd_n_o  out  1  bridge read strobe, active low.
a2_bridge_wr_n_o  out  1  bridge write strobe, active low.
a2_bridge_d_o  out  8  bridge write data.
a2_bridge_d_oe_o  out  1  bridge data output enable.
a2_bridge_d_i  in  8  bridge read data.

Behaviour:
Reset (synchronous, while device_reset = 1):
- State is IDLE.
- a2_bridge_sel_o = IDLE_SEL, rd_n = 1, wr_n = 1, d_o = 0, d_oe = 0.
- ack_o = 0, rdata_o = 0, idle_data_o = 0, idle_valid_o = 0, busy_o = 0.
- All counters = 0.
- Reset asserted mid-transfer aborts it, with no ack. Requesters must reissue.

All outputs are registered.

IDLE state:
- Outputs: sel = IDLE_SEL, rd_n = 0, wr_n = 1, d_oe = 0.
- idle_cnt increments each IDLE cycle and saturates at 15.
- When idle_cnt >= IDLE_SETTLE: idle_data_o <= d_i and idle_valid_o pulses.
- idle_cnt clears on leaving IDLE.

Arbitration (evaluated in IDLE only):
- The winner is the lowest index k with req_i[k] = 1, excluding a requester whose ack_o is high this cycle. This masks a req that has not yet dropped.
- On a win, latch k, we_i[k], sel_i slice and wdata_i slice, then go to SETUP next cycle.
- A transfer in progress is never preempted. Requests arriving mid-transfer wait for IDLE.
- Back-to-back transfers are allowed: the ack cycle is itself an IDLE cycle and may grant.

SETUP (SETUP_CYCLES cycles):
- sel = latched select, rd_n = 1, wr_n = 1.
- d_o = latched wdata; d_oe = latched we.

STROBE (STROBE_CYCLES cycles):
- Select and data unchanged.
- Write: wr_n = 0. Read: rd_n = 0.
- Read only: on the last STROBE cycle, rdata_o <= d_i.

HOLD (HOLD_CYCLES cycles):
- Strobes released (rd_n = wr_n = 1); select, d_o and d_oe unchanged.
- After the last HOLD cycle, go to IDLE with ack_o[k] = 1 for exactly that first IDLE cycle.
- rdata_o is valid when ack_o rises and holds until the next read completes.

Timing:
- Phase counters are 4-bit; each counts from 0 to PARAM-1.
- Total transfer = SETUP + STROBE + HOLD cycles.
- Latency with defaults: req sampled at cycle 0 (IDLE); SETUP at cycle 1; STROBE at cycle 2; HOLD at cycle 3; ack at cycle 4.
- Simultaneous requests: served strictly by index. A continuously asserted low-index req can starve higher indices; this is accepted by design.
- A req dropped before grant is simply not served.
- sel_i, we_i and wdata_i may change after grant without effect.

Test Plan:
1. Single read: req_i=4'b0100, we=0, sel_i[8:6]=3'd2, d_i=8'hA5 during STROBE → sel=2 on cycles 1–3, rd_n=0 only on cycle 2, ack_o=4'b0100 on cycle 4, rdata_o=8'hA5.
2. Single write: req_i[1], we=1, sel=3'd1, wdata=8'h3C → d_oe=1 and d_o=8'h3C on cycles 1–3, wr_n=0 on cycle 2 only, rd_n=1 on cycles 1–3, ack on cycle 4.
3. Contention: req_i=4'b1011 all asserted at once, each dropped on its own ack → grants in order 0, 1, 3; acks 4 cycles apart; no idle gap between transfers.
4. Held req: requester 0 keeps req high for one cycle after ack, requester 2 also requesting → requester 2 is granted on the ack cycle; requester 0 is not re-served.
5. Idle sampling: IDLE_SETTLE=3, d_i=8'h7E, 6 idle cycles → idle_valid_o high on idle cycles 3–6 (counting from 1), idle_data_o=8'h7E, rd_n=0, sel=IDLE_SEL.
6. Reset mid-STROBE of a write → next cycle wr_n=1, d_oe=0, sel=IDLE_SEL, no ack; after reset the pending req is re-granted from SETUP.
